month_year_counter: RTL

MONTH_YEAR_COUNTER -- requirements
Module: month_year_counter

---
 rtl/month_year_counter.sv | 90 +++++++++
 1 files changed

// File: rtl/month_year_counter.sv
// month_year_counter: month/year register pair for a calendar chain.
// Advances one month per one_month pulse, rolls DEC->JAN into the year,
// accepts presets through load, and flags rejected presets with load_err.
// leap_year and month_days are combinational views of the registers.
// Compile-time option: CENTURY_RULE_EN selects the full Gregorian leap rule;
// when undefined, every year divisible by 4 is a leap year.
module month_year_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        one_month,
   input  logic        load,
   input  logic [3:0]  load_month,
   input  logic [11:0] load_year,
   output logic [3:0]  month,
   output logic [11:0] year,
   output logic        leap_year,
   output logic [4:0]  month_days,
   output logic        one_year,
   output logic        load_err
);

   localparam logic [3:0]  JAN = 4'd1;
   localparam logic [3:0]  FEB = 4'd2;
   localparam logic [3:0]  MAR = 4'd3;
   localparam logic [3:0]  APR = 4'd4;
   localparam logic [3:0]  JUN = 4'd6;
   localparam logic [3:0]  SEP = 4'd9;
   localparam logic [3:0]  NOV = 4'd11;
   localparam logic [3:0]  DEC = 4'd12;

   localparam logic [11:0] RESET_YEAR = 12'd2024;

   logic load_ok;

   // A preset is accepted only when it names a real month, which keeps
   // the month register inside 1..12 in every reachable state.
   assign load_ok = (load_month >= JAN) && (load_month <= DEC);

   // Month/year state: reset beats load, load beats one_month.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent
   // races between month, year and the pulse flags.
   always_ff @(posedge clk) begin
      one_year <= 1'b0;
      load_err <= 1'b0;
      if (reset) begin
         month <= MAR;
         year  <= RESET_YEAR;
      end else if (load) begin
         if (load_ok) begin
            month <= load_month;
            year  <= load_year;
         end else begin
            load_err <= 1'b1;
         end
      end else if (one_month) begin
         if (month == DEC) begin
            month    <= JAN;
            year     <= year + 12'd1;  // 12-bit add wraps 4095 -> 0
            one_year <= 1'b1;
         end else begin
            month <= month + 4'd1;
         end
      end
   end

   // Leap-year decode straight from the year register, no added latency.
   // NOTE: every combinational output gets a default before any branch so
   // no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      leap_year = 1'b0;
`ifdef CENTURY_RULE_EN
      leap_year = (((year % 12'd4) == 12'd0) && ((year % 12'd100) != 12'd0))
                  || ((year % 12'd400) == 12'd0);
`else
      leap_year = (year[1:0] == 2'b00);
`endif
   end

   // Length of the current month for the day counter.
   always_comb begin
      month_days = 5'd31;
      case (month)
         APR, JUN, SEP, NOV: month_days = 5'd30;
         FEB:                month_days = 5'd28 + {4'd0, leap_year};
         default:            month_days = 5'd31;
      endcase
   end

endmodule
